bus_master: RTL and testbench
=============================

# bus_master

Bus initiator for the single-master 64-bit system bus: accepts read/write commands from a local client through a small command FIFO and runs each one as one bus transaction over m_req/m_grant. Sits between a client (core load/store unit, DMA sequencer) and the bus arbiter, which decodes s0 (0x0000–0x07FF) and s1 (0x7000–0x71FF). Each command produces a one-cycle response carrying read data and an error flag.

## Interface
- FIFO_DEPTH, 2: command FIFO entries; power of two, ≥2.
- TIMEOUT_CYCLES, 255: grant/transfer watchdog limit; used only with BUS_MASTER_TIMEOUT_EN.
- clk  in  1  sole clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  client command present.
- cmd_ready  out  1  FIFO not full; command accepted on cmd_valid && cmd_ready.
- cmd_wr  in  1  1 = write, 0 = read.
- cmd_addr  in  16  bus address.
- cmd_wdata  in  64  write data.
- rsp_valid  out  1  one-cycle response pulse; no backpressure.
- rsp_rdata  out  64  read data; 0 for writes and errored commands.
- rsp_err  out  1  unmapped address or timeout.
- busy  out  1  FSM not IDLE or FIFO not empty.
- m_req  out  1  bus request.
- m_wr, m_addr[15:0], m_dout[63:0]  out  bus command fields, registered.
- m_grant  in  1  arbiter grant.
- m_din  in  64  read data from the arbiter.

## Operation
- Reset: FSM IDLE, FIFO empty, m_req=0, m_wr=0, m_addr=0, m_dout=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0; cmd_ready=1 from the first cycle after reset.
- FSM states: IDLE, REQ, XFER, RESP.
- IDLE: FIFO non-empty → pop head, load m_addr/m_wr/m_dout, set m_req=1, go REQ.
- REQ: hold m_req=1 and all command fields; on m_grant=1 → m_req=0, capture m_din, go XFER.
- XFER: capture m_din every cycle m_grant=1; on m_grant=0 → go RESP; last captured value is the read data.
- RESP: rsp_valid=1 for exactly this cycle; rsp_rdata = captured data for mapped reads, else 0; then IDLE.
- m_addr/m_wr/m_dout stay stable from entering REQ until leaving RESP.
- Address check at pop: unmapped (outside both windows) → transaction still runs, rsp_err=1, rsp_rdata=0.
- FIFO: simultaneous push and pop allowed when full; push with FIFO full is ignored (cmd_ready=0); pointers wrap modulo FIFO_DEPTH.
- Reset during any state: abort immediately, drop m_req, discard FIFO contents, no response.

## Timing
- Command accepted at edge k with FIFO empty and FSM IDLE → m_req=1 after edge k+1.
- m_req falls on the edge after the first m_grant=1 sample.
- m_grant falls observed at edge g → rsp_valid high for the cycle after edge g+1.
- Gap between transactions: at least 2 cycles with m_req=0 after grant drops, so the arbiter is in its idle state before the next request.
- Throughput: one transaction in flight; the FIFO decouples the client.

## Configuration
- BUS_MASTER_TIMEOUT_EN defined: 8-bit-or-wider counter cleared on entering REQ and XFER; reaching TIMEOUT_CYCLES in REQ → m_req=0, go RESP with rsp_err=1, rsp_rdata=0; the same applies in XFER, and the FSM then waits for m_grant=0 before RESP.
- Undefined: no counter; REQ/XFER wait indefinitely; rsp_err reports unmapped addresses only.

## Structure
- Shared package: FSM state encoding, address window constants (S0_BASE/S0_LAST, S1_BASE/S1_LAST), bus data/address widths.
- One sub-module: bus_cmd_fifo (synchronous FIFO, 81-bit entry {wr, addr, wdata}, FIFO_DEPTH deep).

## Test plan
- Write 0x0010 data 0xDEAD_BEEF_0000_0001; arbiter model grants after 1 cycle and holds for 2 → m_addr=0x0010, m_wr=1 stable; one rsp_valid; rsp_err=0; rsp_rdata=0.
- Read 0x7004; model returns 0x1234_5678_9ABC_DEF0 on the last grant cycle → rsp_rdata=0x1234_5678_9ABC_DEF0, rsp_err=0.
- Read 0x3000 (unmapped) → bus transaction occurs; rsp_err=1; rsp_rdata=0.
- Push 3 commands back-to-back with FIFO_DEPTH=2 → cmd_ready=0 after two accepts; all three complete in order; m_req low for ≥2 cycles between transactions.
- Reset asserted in XFER → next cycle m_req=0, busy=0, no rsp_valid.
- With BUS_MASTER_TIMEOUT_EN and TIMEOUT_CYCLES=8, grant never asserted → m_req drops after 8 REQ cycles; rsp_valid with rsp_err=1.

Source files
------------

// File: rtl/bus_master_pkg.sv
// Shared definitions for the bus_master block: widths, FSM encoding and the
// decoded address windows of the system bus.
package bus_master_pkg;

  localparam int ADDR_W  = 16;
  localparam int DATA_W  = 64;
  localparam int ENTRY_W = 1 + ADDR_W + DATA_W;

  localparam logic [ADDR_W-1:0] S0_BASE = 16'h0000;
  localparam logic [ADDR_W-1:0] S0_LAST = 16'h07FF;
  localparam logic [ADDR_W-1:0] S1_BASE = 16'h7000;
  localparam logic [ADDR_W-1:0] S1_LAST = 16'h71FF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_XFER = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  // Offset-from-base compare keeps the check uniform even when a base is zero.
  function automatic logic addr_mapped(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] off0;
    logic [ADDR_W-1:0] off1;
    off0 = a - S0_BASE;
    off1 = a - S1_BASE;
    return (off0 <= (S0_LAST - S0_BASE)) || (off1 <= (S1_LAST - S1_BASE));
  endfunction

endpackage

// File: rtl/bus_cmd_fifo.sv
// Synchronous command FIFO holding {wr, addr, wdata}; a push is taken when
// full only if the head is popped in the same cycle.
module bus_cmd_fifo
  import bus_master_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int W     = ENTRY_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] wdata,
  output logic         ready,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] r_mem [DEPTH];
  logic [AW:0]  r_wptr;
  logic [AW:0]  r_rptr;
  logic         w_full;
  logic         w_do_pop;
  logic         w_do_push;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty     = (r_wptr == r_rptr);
  assign w_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_do_pop  = pop && !empty;
  assign ready     = !w_full || w_do_pop;
  assign w_do_push = push && ready;
  assign rdata     = r_mem[r_rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/bus_master.sv
// Single-transaction bus initiator fed by a command FIFO. Optional watchdog on
// the grant/transfer phases is enabled with BUS_MASTER_TIMEOUT_EN.
module bus_master
  import bus_master_pkg::*;
#(
  parameter int FIFO_DEPTH     = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_wr,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              busy,
  output logic              m_req,
  output logic              m_wr,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_dout,
  input  logic              m_grant,
  input  logic [DATA_W-1:0] m_din
);

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("bus_master: FIFO_DEPTH must be a power of two >= 2 and TIMEOUT_CYCLES >= 1");
  end

  logic               w_empty;
  logic               w_pop;
  logic [ENTRY_W-1:0] w_head;
  logic               w_head_wr;
  logic [ADDR_W-1:0]  w_head_addr;
  logic [DATA_W-1:0]  w_head_data;

  state_t             r_state;
  logic               r_err;
  logic               r_tmo;
  logic [DATA_W-1:0]  r_rdata;

`ifdef BUS_MASTER_TIMEOUT_EN
  localparam int TMO_W = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  logic [TMO_W-1:0] r_tmo_cnt;
`endif

  assign {w_head_wr, w_head_addr, w_head_data} = w_head;
  assign w_pop = (r_state == ST_IDLE) && !w_empty;
  assign busy  = (r_state != ST_IDLE) || !w_empty;

  bus_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (ENTRY_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (cmd_valid),
    .wdata ({cmd_wr, cmd_addr, cmd_wdata}),
    .ready (cmd_ready),
    .pop   (w_pop),
    .rdata (w_head),
    .empty (w_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_err     <= 1'b0;
      r_tmo     <= 1'b0;
      r_rdata   <= '0;
      m_req     <= 1'b0;
      m_wr      <= 1'b0;
      m_addr    <= '0;
      m_dout    <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
`ifdef BUS_MASTER_TIMEOUT_EN
      r_tmo_cnt <= '0;
`endif
    end else begin
      rsp_valid <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (!w_empty) begin
            m_wr    <= w_head_wr;
            m_addr  <= w_head_addr;
            m_dout  <= w_head_data;
            m_req   <= 1'b1;
            r_err   <= !addr_mapped(w_head_addr);
            r_tmo   <= 1'b0;
            r_rdata <= '0;
`ifdef BUS_MASTER_TIMEOUT_EN
            r_tmo_cnt <= '0;
`endif
            r_state <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (m_grant) begin
            m_req   <= 1'b0;
            r_rdata <= m_din;
`ifdef BUS_MASTER_TIMEOUT_EN
            r_tmo_cnt <= '0;
`endif
            r_state <= ST_XFER;
          end
`ifdef BUS_MASTER_TIMEOUT_EN
          else if (r_tmo_cnt == TMO_LAST) begin
            m_req   <= 1'b0;
            r_tmo   <= 1'b1;
            r_state <= ST_RESP;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
          end
`endif
        end
        ST_XFER: begin
          // After a transfer timeout, stop capturing but let the arbiter finish.
          if (!m_grant) begin
            r_state <= ST_RESP;
          end else if (!r_tmo) begin
            r_rdata <= m_din;
`ifdef BUS_MASTER_TIMEOUT_EN
            if (r_tmo_cnt == TMO_LAST) r_tmo <= 1'b1;
            else                       r_tmo_cnt <= r_tmo_cnt + 1'b1;
`endif
          end
        end
        ST_RESP: begin
          rsp_valid <= 1'b1;
          rsp_err   <= r_err || r_tmo;
          rsp_rdata <= (!m_wr && !r_err && !r_tmo) ? r_rdata : '0;
          r_state   <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_master.sv
// Directed testbench for bus_master with a behavioural arbiter and a response
// monitor. Define BUS_MASTER_TIMEOUT_EN to also exercise the grant watchdog.
module tb_bus_master;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_wr;
  logic [15:0] cmd_addr;
  logic [63:0] cmd_wdata;
  logic        rsp_valid;
  logic [63:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;
  logic        m_req;
  logic        m_wr;
  logic [15:0] m_addr;
  logic [63:0] m_dout;
  logic        m_grant;
  logic [63:0] m_din;

  always #5 clk = ~clk;

  bus_master #(
    .FIFO_DEPTH     (2),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_wr    (cmd_wr),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .busy      (busy),
    .m_req     (m_req),
    .m_wr      (m_wr),
    .m_addr    (m_addr),
    .m_dout    (m_dout),
    .m_grant   (m_grant),
    .m_din     (m_din)
  );

  int n_checks = 0;
  int n_errs   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Arbiter model: grants gnt_delay cycles after seeing m_req, holds for
  // gnt_len cycles, and drives arb_rdata only on the last grant cycle.
  bit          arb_en;
  int          gnt_delay;
  int          gnt_len;
  logic [63:0] arb_rdata;

  initial begin
    m_grant = 1'b0;
    m_din   = '0;
    forever begin
      @(negedge clk);
      if (arb_en && m_req && !reset) begin
        repeat (gnt_delay) @(negedge clk);
        for (int i = 0; i < gnt_len; i++) begin
          m_grant = 1'b1;
          m_din   = (i == gnt_len - 1) ? arb_rdata : (64'hBAD0_0000_0000_0000 | 64'(i));
          @(negedge clk);
        end
        m_grant = 1'b0;
        m_din   = '0;
      end
    end
  end

  // Monitor sampling just after each rising edge.
  int          cyc       = 0;
  int          fall_cyc  = 0;
  logic        prev_req  = 1'b0;
  logic        prev_gnt  = 1'b0;
  int          low_run   = 0;
  int          high_run  = 0;
  int          last_high = 0;
  int          min_gap   = 1000;
  int          n_rise    = 0;
  logic [15:0] rise_addr_q [$];
  logic        rq_err  [$];
  logic [63:0] rq_data [$];
  logic [15:0] rq_addr [$];
  logic        rq_wr   [$];
  int          rq_lat  [$];

  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (prev_gnt && !m_grant) fall_cyc = cyc;
      if (m_req) begin
        if (!prev_req) begin
          if (n_rise > 0 && low_run < min_gap) min_gap = low_run;
          n_rise++;
          rise_addr_q.push_back(m_addr);
        end
        high_run++;
        low_run = 0;
      end else begin
        if (prev_req) last_high = high_run;
        high_run = 0;
        low_run++;
      end
      if (rsp_valid) begin
        rq_err.push_back(rsp_err);
        rq_data.push_back(rsp_rdata);
        rq_addr.push_back(m_addr);
        rq_wr.push_back(m_wr);
        rq_lat.push_back(cyc - fall_cyc);
      end
      prev_req = m_req;
      prev_gnt = m_grant;
    end
  end

  task automatic send(input logic wr, input logic [15:0] a, input logic [63:0] d);
    int t;
    t         = 0;
    cmd_valid = 1'b1;
    cmd_wr    = wr;
    cmd_addr  = a;
    cmd_wdata = d;
    while (!cmd_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!cmd_ready) check("send_stall", 64'(cmd_ready), 64'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int n);
    int t;
    t = 0;
    while (rq_err.size() < n && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (rq_err.size() < n) check("rsp_wait", 64'(rq_err.size()), 64'(n));
  endtask

  task automatic check_rsp(input string tag, input logic exp_err, input logic [63:0] exp_data,
                           input logic [15:0] exp_addr, input logic exp_wr, input bit chk_lat);
    if (rq_err.size() == 0 || rise_addr_q.size() == 0) begin
      check({tag, "_missing"}, 64'd0, 64'd1);
      return;
    end
    check({tag, "_err"},      64'(rq_err.pop_front()),      64'(exp_err));
    check({tag, "_rdata"},    rq_data.pop_front(),          exp_data);
    check({tag, "_addr"},     64'(rq_addr.pop_front()),     64'(exp_addr));
    check({tag, "_wr"},       64'(rq_wr.pop_front()),       64'(exp_wr));
    check({tag, "_req_addr"}, 64'(rise_addr_q.pop_front()), 64'(exp_addr));
    if (chk_lat) check({tag, "_lat"}, 64'(rq_lat.pop_front()), 64'd1);
    else         void'(rq_lat.pop_front());
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog simulation did not finish got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_wr    = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    arb_en    = 1'b1;
    gnt_delay = 1;
    gnt_len   = 2;
    arb_rdata = 64'hFFFF_0000_FFFF_0000;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Reset state
    check("rst_m_req",     64'(m_req),     64'd0);
    check("rst_m_wr",      64'(m_wr),      64'd0);
    check("rst_m_addr",    64'(m_addr),    64'd0);
    check("rst_m_dout",    m_dout,         64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_rdata", rsp_rdata,      64'd0);
    check("rst_rsp_err",   64'(rsp_err),   64'd0);
    check("rst_busy",      64'(busy),      64'd0);
    check("rst_cmd_ready", 64'(cmd_ready), 64'd1);

    // Write to s0: data never returned, request one cycle after the pop
    send(1'b1, 16'h0010, 64'hDEAD_BEEF_0000_0001);
    check("wr_req_early", 64'(m_req), 64'd0);
    @(negedge clk);
    check("wr_req",  64'(m_req),  64'd1);
    check("wr_addr", 64'(m_addr), 64'h0010);
    check("wr_wr",   64'(m_wr),   64'd1);
    check("wr_dout", m_dout,      64'hDEAD_BEEF_0000_0001);
    wait_rsp(1);
    check_rsp("wr", 1'b0, 64'd0, 16'h0010, 1'b1, 1'b1);
    repeat (4) @(negedge clk);
    check("wr_single_pulse", 64'(rq_err.size()), 64'd0);

    // Read from s1: last grant-cycle data is returned
    gnt_len   = 3;
    arb_rdata = 64'h1234_5678_9ABC_DEF0;
    send(1'b0, 16'h7004, 64'd0);
    wait_rsp(1);
    check_rsp("rd_s1", 1'b0, 64'h1234_5678_9ABC_DEF0, 16'h7004, 1'b0, 1'b1);

    // Unmapped read still runs on the bus
    gnt_len = 2;
    send(1'b0, 16'h3000, 64'd0);
    wait_rsp(1);
    check_rsp("rd_unmapped", 1'b1, 64'd0, 16'h3000, 1'b0, 1'b1);

    // Three commands back-to-back against a slow arbiter
    repeat (4) @(negedge clk);
    gnt_delay = 3;
    gnt_len   = 1;
    arb_rdata = 64'hCAFE_F00D_5555_AAAA;
    min_gap   = 1000;
    send(1'b1, 16'h0100, 64'h0000_0000_0000_0001);
    send(1'b0, 16'h7100, 64'd0);
    send(1'b0, 16'h07FF, 64'd0);
    check("b2b_cmd_ready_full", 64'(cmd_ready), 64'd0);
    check("b2b_busy",           64'(busy),      64'd1);
    wait_rsp(3);
    check_rsp("b2b_a", 1'b0, 64'd0,                  16'h0100, 1'b1, 1'b1);
    check_rsp("b2b_b", 1'b0, 64'hCAFE_F00D_5555_AAAA, 16'h7100, 1'b0, 1'b1);
    check_rsp("b2b_c", 1'b0, 64'hCAFE_F00D_5555_AAAA, 16'h07FF, 1'b0, 1'b1);
    check("b2b_gap_ge2", 64'(min_gap >= 2), 64'd1);

    // Reset during XFER with a second command queued
    repeat (4) @(negedge clk);
    gnt_delay = 1;
    gnt_len   = 6;
    send(1'b0, 16'h0020, 64'd0);
    send(1'b0, 16'h7008, 64'd0);
    begin
      int t;
      t = 0;
      @(negedge clk);
      #1;
      while (!(m_grant && !m_req) && t < 100) begin
        @(negedge clk);
        #1;
        t++;
      end
      check("xrst_reach_xfer", 64'(m_grant && !m_req), 64'd1);
    end
    reset = 1'b1;
    @(negedge clk);
    check("xrst_m_req",     64'(m_req),     64'd0);
    check("xrst_busy",      64'(busy),      64'd0);
    check("xrst_rsp_valid", 64'(rsp_valid), 64'd0);
    reset = 1'b0;
    repeat (12) @(negedge clk);
    check("xrst_no_rsp",    64'(rq_err.size()), 64'd0);
    check("xrst_idle_busy", 64'(busy),          64'd0);
    rise_addr_q.delete();
    rq_lat.delete();

`ifdef BUS_MASTER_TIMEOUT_EN
    // Grant never comes: request dropped after TIMEOUT_CYCLES in REQ
    arb_en = 1'b0;
    send(1'b0, 16'h0010, 64'd0);
    wait_rsp(1);
    check("tmo_req_cycles", 64'(last_high), 64'd8);
    check_rsp("tmo", 1'b1, 64'd0, 16'h0010, 1'b0, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule
